// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority token, registered one-hot
// grant, hold/release handshake and optional maximum-tenure limit.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; scan req from the token position each edge
// GRANT | one requester owns the resource until it drops req or hits MAX_HOLD
module ring_rr_arbiter #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic           expired,
    output logic [N-1:0]   ptr
);

    localparam int HCW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_ONE = HCW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state;
    logic [HCW-1:0] hold_cnt;

    logic [IDW-1:0] ptr_idx;
    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [N-1:0]   win_oh;
    logic [N-1:0]   win_rot;
    logic           owner_req;
    logic           limit_hit;
    int             scan_pos;

    // Circular scan starting at the token bit; first set request wins.
    always_comb begin
        ptr_idx   = '0;
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        scan_pos  = 0;
        for (int i = 0; i < N; i++) begin
            if (ptr[i]) begin
                ptr_idx = IDW'(i);
            end
        end
        for (int k = 0; k < N; k++) begin
            scan_pos = int'(ptr_idx) + k;
            if (scan_pos >= N) begin
                scan_pos = scan_pos - N;
            end
            if (!win_found && req[scan_pos]) begin
                win_found = 1'b1;
                win_idx   = IDW'(scan_pos);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (win_found && (IDW'(i) == win_idx)) begin
                win_oh[i] = 1'b1;
            end
        end
        win_rot = {win_oh[N-2:0], win_oh[N-1]};
    end

    assign owner_req = req[grant_id];
    assign limit_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX);
    assign busy      = (state == GRANT);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            hold_cnt <= '0;
            expired  <= 1'b0;
            ptr      <= {{(N-1){1'b0}}, 1'b1};
        end else begin
            expired <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state    <= GRANT;
                        grant    <= win_oh;
                        grant_id <= win_idx;
                        hold_cnt <= HOLD_ONE;
                        ptr      <= win_rot;
                    end
                end
                GRANT: begin
                    if (!owner_req || limit_hit) begin
                        state    <= IDLE;
                        grant    <= '0;
                        grant_id <= '0;
                        hold_cnt <= '0;
                        expired  <= owner_req;
                    end else if (MAX_HOLD != 0 && hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed bench for ring_rr_arbiter (N=4, MAX_HOLD=8) with hand-computed expectations.
module tb_ring_rr_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       expired;
    logic [3:0] ptr;

    int checks = 0;
    int errors = 0;

    ring_rr_arbiter #(.N(4), .IDW(2), .MAX_HOLD(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .expired  (expired),
        .ptr      (ptr)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                           input logic ex, input logic [3:0] p);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".grant_id"}, 32'(grant_id), 32'(id));
        chk({tag, ".busy"}, 32'(busy), 32'(|g));
        chk({tag, ".expired"}, 32'(expired), 32'(ex));
        chk({tag, ".ptr"}, 32'(ptr), 32'(p));
    endtask

    logic [3:0] exp_g;
    logic [3:0] exp_p;

    initial begin
        reset = 1'b0;
        req   = 4'b0000;

        // reset held for three edges with random requests
        for (int i = 0; i < 3; i++) begin
            req = 4'($urandom_range(0, 15));
            tick();
            chk_out("reset", 4'b0000, 2'd0, 1'b0, 4'b0001);
        end
        req   = 4'b0000;
        reset = 1'b1;
        tick();
        chk_out("idle_after_reset", 4'b0000, 2'd0, 1'b0, 4'b0001);

        // single requester, three cycles of tenure
        req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("single_hold", 4'b0001, 2'd0, 1'b0, 4'b0010);
        end
        req = 4'b0000;
        tick();
        chk_out("single_release", 4'b0000, 2'd0, 1'b0, 4'b0010);

        // all requesting, MAX_HOLD forces rotation
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req   = 4'b1111;
        tick();
        for (int r = 0; r < 5; r++) begin
            exp_g = 4'b0001 << (r % 4);
            exp_p = 4'b0001 << ((r + 1) % 4);
            for (int c = 0; c < 8; c++) begin
                chk_out("maxhold_tenure", exp_g, 2'(r % 4), 1'b0, exp_p);
                if (c < 7) tick();
            end
            tick();
            chk_out("maxhold_gap", 4'b0000, 2'd0, 1'b1, exp_p);
            tick();
        end
        // now granted to 0010 again (sixth tenure start)
        chk_out("maxhold_wrap", 4'b0010, 2'd1, 1'b0, 4'b0100);
        req = 4'b0000;
        tick();
        chk_out("maxhold_drop", 4'b0000, 2'd0, 1'b0, 4'b0100);

        // token at 0100: req=1011 served 1000, 0001, 0010
        req = 4'b1011;
        tick();
        chk_out("rr_first", 4'b1000, 2'd3, 1'b0, 4'b0001);
        tick();
        req = 4'b0011;
        tick();
        chk_out("rr_gap1", 4'b0000, 2'd0, 1'b0, 4'b0001);
        tick();
        chk_out("rr_second", 4'b0001, 2'd0, 1'b0, 4'b0010);
        tick();
        req = 4'b0010;
        tick();
        chk_out("rr_gap2", 4'b0000, 2'd0, 1'b0, 4'b0010);
        tick();
        chk_out("rr_third", 4'b0010, 2'd1, 1'b0, 4'b0100);
        tick();
        req = 4'b0000;
        tick();
        chk_out("rr_end", 4'b0000, 2'd0, 1'b0, 4'b0100);

        // reset in the middle of requester 2's tenure
        req = 4'b0100;
        tick();
        chk_out("mid_tenure", 4'b0100, 2'd2, 1'b0, 4'b1000);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_out("mid_reset", 4'b0000, 2'd0, 1'b0, 4'b0001);
        reset = 1'b1;
        tick();
        chk_out("post_reset", 4'b0100, 2'd2, 1'b0, 4'b1000);
        req = 4'b0000;
        tick();
        chk_out("post_reset_drop", 4'b0000, 2'd0, 1'b0, 4'b1000);

        // owner drops while another raises at the same edge
        req = 4'b0001;
        tick();
        chk_out("swap_own", 4'b0001, 2'd0, 1'b0, 4'b0010);
        tick();
        req = 4'b1000;
        tick();
        chk_out("swap_gap", 4'b0000, 2'd0, 1'b0, 4'b0010);
        tick();
        chk_out("swap_new", 4'b1000, 2'd3, 1'b0, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
